// File: rtl/streaming_merged_permutation.sv
// Streaming frame permuter: buffers SIZE coefficients arriving LANES per beat, then
// emits them reordered by identity, generator, inverse-generator or negation index maps.
module streaming_merged_permutation #(
  parameter int WIDTH   = 32,
  parameter int SIZE    = 257,
  parameter int LANES   = 4,
  parameter int GEN     = 3,
  parameter int GEN_INV = 86
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int BEATS      = (SIZE + LANES - 1) / LANES;
  localparam int LAST_LANES = SIZE - (BEATS - 1) * LANES;
  localparam int IW         = $clog2(SIZE);
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Effective multiplier of each mode; only ever evaluated at elaboration time.
  function automatic int map_mult(input int m);
    int r;
    case (m)
      0:       r = 1;
      1:       r = GEN % SIZE;
      2:       r = GEN_INV % SIZE;
      default: r = SIZE - 1;
    endcase
    return r;
  endfunction

  function automatic int mod_mul(input int m, input int x);
    longint p;
    p = longint'(map_mult(m)) * longint'(x);
    return int'(p % longint'(SIZE));
  endfunction

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q;
  logic [BW-1:0]          in_beat_q, out_beat_q;
  logic [IW-1:0]          idx_q [LANES];
  logic                   out_valid_q, out_last_q, busy_q;
  logic [LANES*WIDTH-1:0] out_data_q;

  logic [WIDTH-1:0]       buf_q  [SIZE];
  logic [WIDTH-1:0]       buf_nx [SIZE];
  logic [SIZE-1:0]        buf_wr;

  logic [IW-1:0]          start_tab [4][LANES];
  logic [IW-1:0]          step_tab  [4];

  logic                   in_fire, out_fire, in_last, load;
  logic [1:0]             mode_eff, cur_mode;
  logic [BW-1:0]          nb;
  logic [IW-1:0]          rd_idx  [LANES];
  logic [IW-1:0]          nxt_idx [LANES];
  logic [IW:0]            sum     [LANES];
  logic [LANES*WIDTH-1:0] ld_data;

  assign in_ready  = (state_q == LOAD);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign in_last  = in_fire && (in_beat_q == BW'(BEATS - 1));
  assign mode_eff = (in_beat_q == '0) ? in_mode : mode_q;
  assign load     = in_last || (out_fire && !out_last_q);

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam logic [IW-1:0] STEP = IW'(mod_mul(m, LANES));
    assign step_tab[m] = STEP;
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam logic [IW-1:0] START = IW'(mod_mul(m, l));
      assign start_tab[m][l] = START;
    end
  end

  // The next-state view of the buffer lets the final input beat be read back in
  // the same cycle, which is what gives the one-cycle frame latency.
  for (genvar i = 0; i < SIZE; i++) begin : g_buf
    localparam int B = i / LANES;
    localparam int L = i % LANES;
    assign buf_wr[i] = in_fire && (in_beat_q == BW'(B));
    assign buf_nx[i] = buf_wr[i] ? in_data[L*WIDTH +: WIDTH] : buf_q[i];
  end

  // NOTE: the coefficient buffer carries no reset; every entry is rewritten before
  // it is read, and leaving it out keeps the reset tree off a SIZE*WIDTH array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (buf_wr[i]) buf_q[i] <= buf_nx[i];
    end
  end

  // NOTE: every variable written here gets a default before any condition, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    nb       = in_last ? '0 : out_beat_q + BW'(1);
    cur_mode = in_last ? mode_eff : mode_q;
    ld_data  = '0;
    for (int l = 0; l < LANES; l++) begin
      rd_idx[l]  = in_last ? start_tab[cur_mode][l] : idx_q[l];
      sum[l]     = {1'b0, rd_idx[l]} + {1'b0, step_tab[cur_mode]};
      nxt_idx[l] = (sum[l] >= (IW+1)'(SIZE)) ? IW'(sum[l] - (IW+1)'(SIZE)) : IW'(sum[l]);
      if ((nb != BW'(BEATS - 1)) || (l < LAST_LANES)) begin
        ld_data[l*WIDTH +: WIDTH] = buf_nx[rd_idx[l]];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (in_last) state_d = DRAIN;
      DRAIN:   if (out_fire && out_last_q) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      mode_q      <= '0;
      in_beat_q   <= '0;
      out_beat_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      for (int l = 0; l < LANES; l++) idx_q[l] <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        in_beat_q <= in_last ? '0 : in_beat_q + BW'(1);
        busy_q    <= 1'b1;
        if (in_beat_q == '0) mode_q <= in_mode;
      end else if (out_fire && out_last_q) begin
        busy_q <= 1'b0;
      end
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ld_data;
        out_last_q  <= (nb == BW'(BEATS - 1));
        out_beat_q  <= nb;
        for (int l = 0; l < LANES; l++) idx_q[l] <= nxt_idx[l];
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/streaming_merged_permutation.md
Name: streaming_merged_permutation

Overview:
- Streaming, handshaked successor of the flat merged-permutation datapath.
- Accepts one frame of SIZE coefficients over ceil(SIZE/LANES) input beats and buffers it.
- Emits the frame re-ordered by one of four index maps selected per frame. The maps are identity, generator stride, inverse-generator stride and negation mod SIZE.
- Sits between NTT stages (Rader/Good-Thomas re-indexing) where a full-width SIZE*WIDTH bus is too costly.

Parameters:
- WIDTH, 32, bits per coefficient.
- SIZE, 257, coefficients per frame; any integer >= 2.
- LANES, 4, coefficients per beat, 1..SIZE.
- GEN, 3, stride multiplier for mode 1; must be coprime to SIZE.
- GEN_INV, 86, stride for mode 2; GEN*GEN_INV mod SIZE = 1 (3*86 = 258).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  high in LOAD.
- in_mode  in  2  permutation select; sampled on the first accepted beat of a frame.
- in_data  in  LANES*WIDTH  lane l at bits [l*WIDTH +: WIDTH]; coefficient index = beat*LANES+l.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  LANES*WIDTH  permuted beat, same lane packing.
- out_last  out  1  marks final beat of the frame.
- busy  out  1  high from first accepted input beat until last output beat accepted.

Behaviour:
- BEATS = ceil(SIZE/LANES). Buffer: SIZE x WIDTH register array.
- Reset (asynchronous, any time) forces the following:
  - state LOAD
  - in_ready 1 after release
  - out_valid 0, out_data 0, out_last 0, busy 0
  - beat counters 0
  - any partial frame discarded; buffer contents need not be cleared
- LOAD state:
  - Beat accepted when in_valid & in_ready. Writes lanes with index < SIZE; padding lanes of the last beat are ignored.
  - First beat latches in_mode into mode_q. in_mode on later beats is ignored.
  - On the BEATS-th beat: in_ready drops next cycle and state goes to DRAIN.
- Mode maps, for output position k:
  - mode 0: out[k] = in[k]
  - mode 1: out[k] = in[(GEN*k) mod SIZE]
  - mode 2: out[k] = in[(GEN_INV*k) mod SIZE]
  - mode 3: out[k] = in[(SIZE-k) mod SIZE]
- Index generation:
  - Per lane, incremental; no multipliers or dividers in the datapath.
  - Effective multiplier M = 1, GEN, GEN_INV, SIZE-1 for modes 0..3.
  - Lane l starts at (M*l) mod SIZE.
  - Each beat adds STEP = (M*LANES) mod SIZE, then subtracts SIZE if result >= SIZE.
  - All per-mode constants are elaboration-time.
- DRAIN state:
  - First output beat is registered. out_valid rises the cycle after the last input beat is accepted, giving latency 1 cycle from last input handshake.
  - out_data, out_last and out_valid are held stable while out_valid & !out_ready.
  - Each handshake loads the next beat in the same cycle, so one beat per cycle under continuous out_ready.
  - Lanes with k >= SIZE in the last beat output 0. out_last = 1 on beat BEATS-1 only.
  - On last beat handshake: out_valid 0 next cycle (unless reloaded), state LOAD, in_ready 1, busy 0.
- No input/output overlap: in_ready = 0 throughout DRAIN. This is single-buffered by design.
- Throughput: 2*BEATS cycles per frame minimum.
- out_ready asserted while out_valid = 0 has no effect.
- in_valid while in_ready = 0 is ignored; no data is lost upstream, which must hold its data.

Test Plan:
Test parameters: SIZE=7, LANES=2, WIDTH=16, GEN=3, GEN_INV=5; input coefficient i = i+1; out_ready held 1 unless stated.
- Mode 0 frame: 4 input beats -> out beats (1,2),(3,4),(5,6),(7,0); out_last on beat 4 only; first out_valid 1 cycle after 4th input handshake.
- Mode 1 -> (1,4),(7,3),(6,2),(5,0). Mode 2 -> (1,6),(4,2),(7,5),(3,0). Mode 3 -> (1,7),(6,5),(4,3),(2,0).
- Backpressure: mode 1 frame with out_ready low for 3 cycles at beat 2 -> out_data stays (7,3) with out_valid 1; sequence unchanged; in_ready stays 0.
- Mode change mid-frame: in_mode=1 on beat 0, in_mode=3 on beats 1-3 -> mode 1 output sequence.
- Reset asserted after 2 input beats (asynchronous, mid-cycle) -> out_valid/busy 0 immediately; next full mode 0 frame outputs exactly (1,2),(3,4),(5,6),(7,0).
- Back-to-back frames with in_valid continuously high -> in_ready 0 during DRAIN; second frame accepted only after out_last handshake; both frames correct.
